// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth sequential multiplier: controller
// state encoding and the add/sub/nop decode of the Booth bit pair.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] ADD = 2'b01;
    localparam logic [1:0] SUB = 2'b10;

    // Q[1:0] = 01 adds M, 10 subtracts M, 00/11 leave A untouched.
    function automatic logic [1:0] booth_op(input logic [1:0] q_pair);
        case (q_pair)
            2'b01:   booth_op = ADD;
            2'b10:   booth_op = SUB;
            default: booth_op = NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_radix2_step.sv
// One combinational radix-2 Booth iteration: conditional A+/-M followed by
// an arithmetic right shift of the {A,Q} pair.
module booth_radix2_step
    import booth_pkg::*;
#(
    parameter int ACC_W = 5
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] m,
    input  logic [ACC_W-1:0] q,
    output logic [ACC_W-1:0] a_next,
    output logic [ACC_W-1:0] q_next
);

    logic [ACC_W-1:0] sum;

    always_comb begin
        sum = a;
        case (booth_op(q[1:0]))
            ADD:     sum = a + m;
            SUB:     sum = a - m;
            default: sum = a;
        endcase
        a_next = {sum[ACC_W-1], sum[ACC_W-1:1]};
        q_next = {sum[0], q[ACC_W-1:1]};
    end

endmodule

// File: rtl/booth_seq_controller.sv
// Sequential radix-2 Booth multiplier controller: accepts an operand pair,
// runs WIDTH Booth steps, then holds the signed product until consumed.
module booth_seq_controller
    import booth_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int ACC_W = WIDTH + 1;
    localparam int CW    = $clog2(WIDTH) + 1;

    state_t             state_reg, state_next;
    logic [ACC_W-1:0]   a_reg, q_reg, m_reg;
    logic [ACC_W-1:0]   a_step, q_step;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] product_reg;
    logic [2*WIDTH:0]   full_step;
    logic               last_step;

    booth_radix2_step #(.ACC_W(ACC_W)) u_step (
        .a      (a_reg),
        .m      (m_reg),
        .q      (q_reg),
        .a_next (a_step),
        .q_next (q_step)
    );

    // Top bit of {A,Q[W:1]} is a redundant sign copy and is dropped.
    assign full_step = {a_step, q_step[ACC_W-1:1]};
    assign last_step = (cnt_reg == CW'(WIDTH - 1));

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= '0;
                        q_reg   <= {multiplier, 1'b0};
                        m_reg   <= {multiplicand[WIDTH-1], multiplicand};
                        cnt_reg <= '0;
                    end
                end
                RUN: begin
                    a_reg   <= a_step;
                    q_reg   <= q_step;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_step) product_reg <= full_step[2*WIDTH-1:0];
                end
                DONE: begin
                    // Clearing on hand-off keeps product at zero outside DONE.
                    if (out_ready) product_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign product = product_reg;

endmodule

// File: tb/tb_booth_seq_controller.sv
// Self-checking bench for booth_seq_controller at WIDTH=4 against a signed
// arithmetic reference model.
module tb_booth_seq_controller;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   multiplicand = '0;
    logic [W-1:0]   multiplier = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*W-1:0] product;
    logic           busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    booth_seq_controller #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .product      (product),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int ia;
        int ib;
        int p;
        ia = $signed(a);
        ib = $signed(b);
        p  = ia * ib;
        return p[2*W-1:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vec_cnt++;
        if ({in_ready, out_valid, busy} !== 3'b100 || product !== '0) begin
            err_cnt++;
            $display("FAIL reset: rdy/vld/busy=%b product=%h, want 100 / 00",
                     {in_ready, out_valid, busy}, product);
        end
        rst_n = 1'b1;
        step();
        $display("reset: rdy/vld/busy=%b product=%h", {in_ready, out_valid, busy}, product);
    endtask

    // Single operation with out_ready high; checks latency, result and return to IDLE.
    task automatic do_mult(input string name, input logic [W-1:0] mc, input logic [W-1:0] mp,
                           input logic [2*W-1:0] want_const);
        int n;
        logic [2*W-1:0] want;
        want = ref_prod(mc, mp);
        out_ready = 1'b1;
        vec_cnt++;
        if (in_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_idle: in_ready=%b want 1", name, in_ready);
        end
        in_valid = 1'b1;
        multiplicand = mc;
        multiplier = mp;
        step();
        in_valid = 1'b0;
        multiplicand = $urandom();
        multiplier = $urandom();
        vec_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_accept: busy=%b in_ready=%b want 1/0", name, busy, in_ready);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        vec_cnt++;
        if (n !== W) begin
            err_cnt++;
            $display("FAIL %s_latency: %0d cycles want %0d", name, n, W);
        end
        vec_cnt++;
        if (product !== want || want !== want_const) begin
            err_cnt++;
            $display("FAIL %s_product: got %h want %h (const %h)", name, product, want, want_const);
        end
        step();
        vec_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
            err_cnt++;
            $display("FAIL %s_return: in_ready=%b out_valid=%b product=%h want 1/0/00",
                     name, in_ready, out_valid, product);
        end
        $display("%s: %0d x %0d -> %h latency %0d", name, $signed(mc), $signed(mp), want, n);
    endtask

    task automatic test_basic();
        do_mult("basic", 4'd3, 4'hE, 8'hFA);
    endtask

    task automatic test_corners();
        do_mult("corner_m8m8", 4'h8, 4'h8, 8'h40);
        do_mult("corner_7m8", 4'h7, 4'h8, 8'hC8);
        do_mult("corner_0m5", 4'h0, 4'hB, 8'h00);
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        in_valid = 1'b1;
        multiplicand = 4'd7;
        multiplier = 4'd7;
        step();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            vec_cnt++;
            if (product !== 8'h31 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                err_cnt++;
                $display("FAIL stall_%0d: product=%h vld=%b rdy=%b busy=%b want 31/1/0/1",
                         i, product, out_valid, in_ready, busy);
            end
            if (i == 3) begin
                in_valid = 1'b1;
                multiplicand = 4'd2;
                multiplier = 4'd2;
            end
            if (i == 4) in_valid = 1'b0;
            step();
        end
        out_ready = 1'b1;
        step();
        step();
        vec_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_release: rdy=%b busy=%b vld=%b want 1/0/0", in_ready, busy, out_valid);
        end
        $display("backpressure: 7 x 7 held 10 cycles, product 31");
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        in_valid = 1'b1;
        multiplicand = 4'd5;
        multiplier = 4'd3;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        vec_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            err_cnt++;
            $display("FAIL midrun_reset: rdy=%b vld=%b busy=%b product=%h want 1/0/0/00",
                     in_ready, out_valid, busy, product);
        end
        for (int i = 0; i < 6; i++) begin
            vec_cnt++;
            if (out_valid !== 1'b0) begin
                err_cnt++;
                $display("FAIL midrun_noemit_%0d: out_valid=%b want 0", i, out_valid);
            end
            step();
        end
        $display("reset_mid_run: operation discarded");
        do_mult("after_reset", 4'd5, 4'd3, 8'h0F);
    endtask

    // Streams n_ops operations; exhaustive order with continuous handshakes,
    // or random operands with random in_valid/out_ready.
    task automatic run_stream(input string name, input int n_ops, input bit rnd);
        logic [2*W-1:0] exp_q[$];
        logic [2*W-1:0] want;
        int  sent;
        int  got;
        int  cyc;
        int  last_xfer;
        bit  accept;
        bit  xfer;
        sent = 0;
        got = 0;
        cyc = 0;
        last_xfer = -1;
        multiplicand = rnd ? W'($urandom()) : W'(0);
        multiplier   = rnd ? W'($urandom()) : W'(0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (got < n_ops && cyc < n_ops * 30 + 50) begin
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                in_valid = (sent < n_ops) && ($urandom_range(0, 1) == 1);
            end
            accept = in_ready && in_valid;
            xfer = out_valid && out_ready;
            if (accept) begin
                exp_q.push_back(ref_prod(multiplicand, multiplier));
                sent++;
            end
            if (xfer) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++;
                    $display("FAIL %s_spurious: product %h with nothing pending", name, product);
                end else begin
                    want = exp_q.pop_front();
                    if (product !== want) begin
                        err_cnt++;
                        $display("FAIL %s_prod_%0d: got %h want %h", name, got, product, want);
                    end
                end
                if (!rnd && last_xfer >= 0) begin
                    vec_cnt++;
                    if (cyc - last_xfer != W + 2) begin
                        err_cnt++;
                        $display("FAIL %s_interval_%0d: %0d cycles want %0d", name, got,
                                 cyc - last_xfer, W + 2);
                    end
                end
                last_xfer = cyc;
                got++;
            end
            step();
            cyc++;
            if (accept) begin
                multiplicand = rnd ? W'($urandom()) : W'(sent >> W);
                multiplier   = rnd ? W'($urandom()) : W'(sent);
                if (!rnd) in_valid = (sent < n_ops);
            end
        end
        vec_cnt++;
        if (got != n_ops) begin
            err_cnt++;
            $display("FAIL %s_timeout: %0d of %0d products seen", name, got, n_ops);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        $display("%s: %0d ops, %0d products, %0d cycles", name, n_ops, got, cyc);
    endtask

    task automatic test_back_to_back();
        run_stream("sweep", 256, 1'b0);
    endtask

    task automatic test_random();
        run_stream("random", 60, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/booth_seq_controller.md
# booth_seq_controller

Sequential control stage for the radix-2 Booth datapath. It accepts a signed multiplicand/multiplier pair over a valid/ready handshake and loads the A/Q/M working registers. It then drives one combinational Booth add/sub-and-shift step per clock for WIDTH cycles and presents the signed 2·WIDTH-bit product over a second valid/ready handshake. It sits directly upstream of the Booth step logic, supplying its A, M and Q inputs and registering its A/Q outputs each cycle.

## Interface
- WIDTH, default 4, operand width in bits; legal values 2..16.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands; high only in IDLE.
- multiplicand  input  WIDTH  signed two's-complement M.
- multiplier  input  WIDTH  signed two's-complement Q.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer accepts the product.
- product  output  2·WIDTH  signed product, multiplicand × multiplier.
- busy  output  1  high in RUN or DONE.

## Operation
- States are IDLE, RUN and DONE, encoded in 2 bits.
- In IDLE, in_ready is 1. When in_valid is 1 at an edge:
  - A is loaded with 0 (WIDTH+1 bits).
  - Q is loaded with {multiplier, 1'b0} (WIDTH+1 bits, Q[0] is the Booth extra bit).
  - M is loaded with multiplicand, sign-extended to WIDTH+1 bits.
  - cnt is loaded with 0, and the state moves to RUN.
- In RUN, each edge registers the step result and increments cnt:
  - Q[1:0] = 00 or 11: shift only.
  - Q[1:0] = 01: A+M, then shift.
  - Q[1:0] = 10: A−M, then shift.
  - Shift is an arithmetic right shift of {A,Q}, with A[0] moving into Q's MSB.
- When the edge performs step WIDTH (cnt = WIDTH−1 before that edge), the state moves to DONE.
- The accumulator is WIDTH+1 bits, so every operand pair is exact, including −2^(WIDTH−1) × −2^(WIDTH−1).
- product = {A, Q[WIDTH:1]}[2·WIDTH−1:0]. The dropped top bit is a redundant sign bit. product is registered and is driven only in DONE; it is 0 otherwise.
- In DONE, out_valid is 1 and product is held stable until out_valid && out_ready at an edge, after which the state returns to IDLE.
- in_valid is ignored while not in IDLE. Operand inputs are sampled only at the acceptance edge.
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, product 0, and A, Q, M, cnt all 0.
- Reset takes priority over every event. Reset mid-RUN or mid-DONE discards the operation, and no product is emitted.

## Timing
- The acceptance edge is E. The RUN steps occur on edges E+1 through E+WIDTH.
- out_valid is high from after edge E+WIDTH.
- Latency from acceptance to out_valid is WIDTH cycles.
- If out_ready is 1 at the first DONE edge, the block is back in IDLE one cycle later, giving a minimum initiation interval of WIDTH+2 cycles.
- There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- out_ready held low stalls DONE indefinitely without loss. in_ready stays 0 for the whole stall.
- cnt width is clog2(WIDTH)+1. cnt never wraps within an operation.

## Structure
- A shared package booth_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the Booth op encoding localparams (NOP, ADD, SUB) decoded from Q[1:0].
- One sub-module, booth_radix2_step, is parameterized on accumulator width WIDTH+1:
  - it is purely combinational;
  - it takes A, M and Q and returns the next A and Q;
  - the controller instantiates it once.
- The controller owns only the FSM, the counter, the registers and the handshakes.

## Test plan
- WIDTH=4, multiplicand 3, multiplier −2, out_ready held 1 -> out_valid rises 4 cycles after acceptance with product 8'hFA (−6); in_ready returns high 1 cycle after the output transfer.
- Corner operands −8 × −8, then 7 × −8, then 0 × −5 -> products 8'h40 (64), 8'hC8 (−56), 8'h00 respectively.
- Backpressure: 7 × 7 with out_ready low for 10 cycles -> product 8'h31 held stable with out_valid high throughout. in_ready and busy stay unchanged, and a second in_valid pulse during the stall is ignored.
- Reset mid-run: rst_n low at the 2nd RUN edge of 5 × 3 -> the next cycle shows IDLE, out_valid 0, product 0, in_ready 1. A following 5 × 3 then yields 8'h0F.
- Back-to-back: in_valid held high with out_ready high -> a new product every 6 cycles. The 16×16-pair exhaustive sweep at WIDTH=4 must match a signed reference model with zero mismatches.
